// File: rtl/lq_entry_issue.sv
// Load-queue issue stage: pops FIFO entries into one hold register and issues them in order under a credit limit.
// Optional statistics counters are built when LQ_ISSUE_STATS_EN is defined.
module lq_entry_issue #(
  parameter type DATA_TYPE = logic,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_valid,
  input  DATA_TYPE      fifo_data,
  output logic          fifo_pop,
  input  logic          flush,
  output logic          mem_req_valid,
  output DATA_TYPE      mem_req_data,
  input  logic          mem_req_ready,
  input  logic          mem_rsp_valid,
  output logic [CW-1:0] outstanding,
  output logic [15:0]   issued_count,
  output logic [15:0]   stall_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FLUSH
  } state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  state_t   state;
  DATA_TYPE hold_data;
  logic     hold_valid;
  logic     credit_ok;
  logic     fire;

  // A response in this cycle frees a slot for a fire in the same cycle.
  always_comb begin
    credit_ok = (outstanding < MAX_CNT) | mem_rsp_valid;
    mem_req_valid = ~rst & hold_valid & credit_ok
                  & (state == HOLD) & ~flush;
    fire = mem_req_valid & mem_req_ready;
    fifo_pop = 1'b0;
    if (!rst) begin
      if (state == FLUSH) begin
        fifo_pop = fifo_valid;
      end else begin
        fifo_pop = fifo_valid & ~flush
                 & (~hold_valid | fire);
      end
    end
  end

  assign mem_req_data = hold_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_valid  <= 1'b0;
      outstanding <= '0;
    end else begin
      if (flush) begin
        state      <= FLUSH;
        hold_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (fifo_pop) begin
              state      <= HOLD;
              hold_valid <= 1'b1;
            end
          end
          HOLD: begin
            if (fire && !fifo_pop) begin
              state      <= IDLE;
              hold_valid <= 1'b0;
            end
          end
          FLUSH: begin
            if (!fifo_valid) begin
              state <= IDLE;
            end
          end
          default: begin
            state      <= IDLE;
            hold_valid <= 1'b0;
          end
        endcase
      end
      // Flush leaves the count alone: accepted loads still respond.
      if (fire && !mem_rsp_valid) begin
        outstanding <= outstanding + CW'(1);
      end else if (!fire && mem_rsp_valid
                   && outstanding != '0) begin
        outstanding <= outstanding - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop && state != FLUSH) begin
      hold_data <= fifo_data;
    end
  end

`ifdef LQ_ISSUE_STATS_EN
  logic [15:0] issued_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (fire && issued_q != 16'hFFFF) begin
        issued_q <= issued_q + 16'd1;
      end
      if (hold_valid && !fire && state != FLUSH
          && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign issued_count = issued_q;
  assign stall_cycles = stall_q;
`else
  assign issued_count = '0;
  assign stall_cycles = '0;
`endif

  a_rsp_nonzero: assert property (
    @(posedge clk) disable iff (rst)
    mem_rsp_valid |-> outstanding != '0
  );

  a_cnt_bound: assert property (
    @(posedge clk) disable iff (rst)
    outstanding <= MAX_CNT
  );

endmodule

// File: tb/tb_lq_entry_issue.sv
// Directed bench for lq_entry_issue: stream, credit, backpressure, flush, empty/reset, stats.
// A small queue models the upstream FIFO; a monitor logs fires and pops.
module tb_lq_entry_issue;

  logic       clk;
  logic       rst;
  logic       fifo_valid;
  logic [7:0] fifo_data;
  logic       fifo_pop;
  logic       flush;
  logic       mem_req_valid;
  logic [7:0] mem_req_data;
  logic       mem_req_ready;
  logic       mem_rsp_valid;
  logic [2:0] outstanding;
  logic [15:0] issued_count;
  logic [15:0] stall_cycles;

  int checks;
  int errors;
  int cycle;
  int pops;
  int max_out;
  bit auto_rsp;
  logic [7:0] q[$];
  logic [7:0] fired[$];
  int fire_cyc[$];

  lq_entry_issue #(
    .DATA_TYPE(logic [7:0]),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_valid(fifo_valid),
    .fifo_data(fifo_data),
    .fifo_pop(fifo_pop),
    .flush(flush),
    .mem_req_valid(mem_req_valid),
    .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .outstanding(outstanding),
    .issued_count(issued_count),
    .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cycle++;
    if (mem_req_valid && mem_req_ready) begin
      fired.push_back(mem_req_data);
      fire_cyc.push_back(cycle);
    end
    if (fifo_pop && q.size() != 0) begin
      void'(q.pop_front());
      pops++;
    end
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
  end

  task automatic refresh();
    fifo_valid = (q.size() != 0);
    fifo_data = fifo_valid ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] v);
    q.push_back(v);
    refresh();
  endtask

  task automatic cyc();
    logic fp;
    fp = mem_req_valid & mem_req_ready;
    @(posedge clk);
    #1;
    refresh();
    mem_rsp_valid = auto_rsp ? fp : 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    auto_rsp = 1'b0;
    q.delete();
    refresh();
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    fired.delete();
    fire_cyc.delete();
    max_out = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    auto_rsp = 1'b0;
    q.delete();
    refresh();
    cyc();
    push(8'hAA);
    #1;
    checks++;
    if (fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL reset_pop got %b want 0", fifo_pop);
    end
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", mem_req_valid);
    end
    checks++;
    if (outstanding !== 3'd0) begin
      errors++;
      $display("FAIL reset_out got %0d want 0", outstanding);
    end
    checks++;
    if (issued_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_issued got %0d want 0", issued_count);
    end
    checks++;
    if (stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall got %0d want 0", stall_cycles);
    end
    do_reset();
  endtask

  task automatic test_stream();
    int c0;
    do_reset();
    auto_rsp = 1'b1;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    #1;
    checks++;
    if (fifo_pop !== 1'b1) begin
      errors++;
      $display("FAIL stream_first_pop got %b want 1", fifo_pop);
    end
    c0 = cycle;
    for (int i = 0; i < 12; i++) cyc();
    checks++;
    if (fired.size() != 8) begin
      errors++;
      $display("FAIL stream_count got %0d want 8", fired.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (fired[i] !== 8'h10 + 8'(i) || fire_cyc[i] != c0 + 2 + i) begin
          errors++;
          $display("FAIL stream_req%0d got %h@%0d want %h@%0d",
                   i, fired[i], fire_cyc[i], 8'h10 + 8'(i), c0 + 2 + i);
        end
      end
    end
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL stream_max_out got %0d want <=2", max_out);
    end
    checks++;
    if (outstanding !== 3'd0) begin
      errors++;
      $display("FAIL stream_drain got %0d want 0", outstanding);
    end
  endtask

  task automatic test_credit();
    do_reset();
    mem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    #1;
    for (int i = 0; i < 8; i++) cyc();
    checks++;
    if (fired.size() != 4) begin
      errors++;
      $display("FAIL credit_fires got %0d want 4", fired.size());
    end
    checks++;
    if (outstanding !== 3'd4) begin
      errors++;
      $display("FAIL credit_out got %0d want 4", outstanding);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL credit_block got v%b p%b want v0 p0",
               mem_req_valid, fifo_pop);
    end
    checks++;
    if (mem_req_data !== 8'h24 || q.size() != 1) begin
      errors++;
      $display("FAIL credit_held got %h q%0d want 24 q1",
               mem_req_data, q.size());
    end
    mem_rsp_valid = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL credit_same_cycle got %b want 1", mem_req_valid);
    end
    cyc();
    checks++;
    if (outstanding !== 3'd4) begin
      errors++;
      $display("FAIL credit_out_after got %0d want 4", outstanding);
    end
    checks++;
    if (fired.size() != 5 || fired[fired.size()-1] !== 8'h24) begin
      errors++;
      $display("FAIL credit_fire5 got n%0d want n5 data 24", fired.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(8'h30);
    push(8'h31);
    push(8'h32);
    #1;
    checks++;
    if (fifo_pop !== 1'b1) begin
      errors++;
      $display("FAIL bp_pop got %b want 1", fifo_pop);
    end
    cyc();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_data !== 8'h30
          || fifo_pop !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v%b d%h p%b want v1 d30 p0",
                 i, mem_req_valid, mem_req_data, fifo_pop);
      end
      cyc();
    end
    mem_req_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (fired.size() != 3 || fired[0] !== 8'h30
        || fired[1] !== 8'h31 || fired[2] !== 8'h32) begin
      errors++;
      $display("FAIL bp_release got n%0d want 30 31 32", fired.size());
    end
    checks++;
    if (mem_req_valid !== 1'b0 || outstanding !== 3'd3) begin
      errors++;
      $display("FAIL bp_after got v%b o%0d want v0 o3",
               mem_req_valid, outstanding);
    end
  endtask

  task automatic test_empty();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (fifo_pop !== 1'b0 || mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty%0d got p%b v%b want p0 v0",
                 i, fifo_pop, mem_req_valid);
      end
      cyc();
    end
    checks++;
    if (outstanding !== 3'd3) begin
      errors++;
      $display("FAIL empty_out got %0d want 3", outstanding);
    end
    rst = 1'b1;
    cyc();
    push(8'h77);
    #1;
    checks++;
    if (outstanding !== 3'd0 || mem_req_valid !== 1'b0
        || fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL midrst got o%0d v%b p%b want o0 v0 p0",
               outstanding, mem_req_valid, fifo_pop);
    end
    checks++;
    if (issued_count !== 16'd0 || stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL midrst_stats got %0d %0d want 0 0",
               issued_count, stall_cycles);
    end
    do_reset();
  endtask

  task automatic test_flush();
    int p0;
    int f0;
    bit done;
    do_reset();
    mem_req_ready = 1'b1;
    push(8'h40);
    #1;
    cyc();
    cyc();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    #1;
    cyc();
    checks++;
    if (outstanding !== 3'd1 || mem_req_valid !== 1'b1 || q.size() != 3) begin
      errors++;
      $display("FAIL flush_setup got o%0d v%b q%0d want o1 v1 q3",
               outstanding, mem_req_valid, q.size());
    end
    p0 = pops;
    f0 = fired.size();
    flush = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL flush_mask got v%b p%b want v0 p0",
               mem_req_valid, fifo_pop);
    end
    cyc();
    flush = 1'b0;
    #1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (q.size() == 0) done = 1'b1;
      else cyc();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL flush_timeout got q%0d want 0", q.size());
    end
    cyc();
    checks++;
    if (pops - p0 != 3 || fired.size() != f0) begin
      errors++;
      $display("FAIL flush_drain got pops%0d fires%0d want 3 0",
               pops - p0, fired.size() - f0);
    end
    checks++;
    if (outstanding !== 3'd1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got o%0d v%b want o1 v0",
               outstanding, mem_req_valid);
    end
    push(8'h60);
    #1;
    checks++;
    if (fifo_pop !== 1'b1) begin
      errors++;
      $display("FAIL flush_next_pop got %b want 1", fifo_pop);
    end
    cyc();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_data !== 8'h60) begin
      errors++;
      $display("FAIL flush_next_req got v%b d%h want v1 d60",
               mem_req_valid, mem_req_data);
    end
    cyc();
    checks++;
    if (fired[fired.size()-1] !== 8'h60 || outstanding !== 3'd2) begin
      errors++;
      $display("FAIL flush_next_fire got %h o%0d want 60 o2",
               fired[fired.size()-1], outstanding);
    end
  endtask

  task automatic test_stats();
    logic [15:0] exp_issued;
    logic [15:0] exp_stall;
    do_reset();
    auto_rsp = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    #1;
    cyc();
    for (int i = 0; i < 7; i++) cyc();
    mem_req_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) cyc();
`ifdef LQ_ISSUE_STATS_EN
    exp_issued = 16'd5;
    exp_stall = 16'd7;
`else
    exp_issued = 16'd0;
    exp_stall = 16'd0;
`endif
    checks++;
    if (fired.size() != 5) begin
      errors++;
      $display("FAIL stats_fires got %0d want 5", fired.size());
    end
    checks++;
    if (issued_count !== exp_issued) begin
      errors++;
      $display("FAIL stats_issued got %0d want %0d",
               issued_count, exp_issued);
    end
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL stats_stall got %0d want %0d",
               stall_cycles, exp_stall);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle = 0;
    pops = 0;
    max_out = 0;
    rst = 1'b1;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    auto_rsp = 1'b0;
    refresh();
    #2;
    test_reset();
    test_stream();
    test_credit();
    test_backpressure();
    test_empty();
    test_flush();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
